// File: rtl/cmd_arbiter2.sv
// Two-requester round-robin command arbiter feeding one shared decoder port.
// Latency: grant edge to out_valid is 1 cycle; at most one word every 2 cycles.
// Backpressure: out_valid holds while out_ready is low; TIMEOUT > 0 drops the word and sets err.
module cmd_arbiter2 #(
    parameter int IN_WIDTH = 7,
    parameter int TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req,
    input  logic [1:0][IN_WIDTH-1:0] in,
    output logic [1:0]               ack,
    output logic [IN_WIDTH-1:0]      out_data,
    output logic                     out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     err_clr,
    output logic                     err,
    output logic                     busy
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   out_data_q, out_data_d;
    logic                  out_sel_q, out_sel_d;
    logic                  last_grant_q, last_grant_d;
    logic [1:0]            ack_q, ack_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic                  grant_idx;
    logic                  timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            out_sel_q    <= 1'b0;
            last_grant_q <= 1'b1;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        ack_d        = 2'b00;
        err_d        = err_q;
        timer_d      = timer_q;
        grant_idx    = 1'b0;
        timeout_hit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie, the requester served last time yields.
                    grant_idx            = (req == 2'b11) ? ~last_grant_q : req[1];
                    out_data_d           = in[grant_idx];
                    out_sel_d            = grant_idx;
                    last_grant_d         = grant_idx;
                    ack_d[grant_idx]     = 1'b1;
                    state_d              = SEND;
                    timer_d              = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (TIMEOUT > 0) begin
                    if (timer_q == TLIM) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as err_clr must still leave err set.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    assign ack       = ack_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign err       = err_q;

endmodule

// File: tb/tb_cmd_arbiter2.sv
// Scoreboard bench for cmd_arbiter2: directed stimulus pushes expected acks/words,
// a negedge monitor pops and compares them as the DUTs present outputs.
module tb_cmd_arbiter2;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [1:0][6:0]  in_w;
    logic [1:0]       ack;
    logic [6:0]       out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;
    logic             err_clr;
    logic             err;
    logic             busy;

    logic [1:0]       b_req;
    logic [1:0]       b_ack;
    logic [6:0]       b_out_data;
    logic             b_out_sel;
    logic             b_out_valid;
    logic             b_out_ready;
    logic             b_err;
    logic             b_busy;

    int               n_checks = 0;
    int               n_fail   = 0;

    logic [1:0]       exp_ack[$];
    logic [7:0]       exp_dat[$];
    logic [1:0]       exp_b_ack[$];
    logic [7:0]       exp_b[$];

    logic             prev_valid_a = 1'b0;
    logic             prev_ready_a = 1'b0;
    logic [7:0]       prev_word_a  = '0;
    logic             prev_valid_b = 1'b0;
    logic             prev_ready_b = 1'b0;
    logic [7:0]       prev_word_b  = '0;
    int               b_valid_cycles = 0;

    logic [6:0]       rr_w0 [4] = '{7'h11, 7'h12, 7'h13, 7'h14};
    logic [6:0]       rr_w1 [4] = '{7'h51, 7'h52, 7'h53, 7'h54};

    cmd_arbiter2 #(.IN_WIDTH(7), .TIMEOUT(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in        (in_w),
        .ack       (ack),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err       (err),
        .busy      (busy)
    );

    cmd_arbiter2 #(.IN_WIDTH(7), .TIMEOUT(16)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .req       (b_req),
        .in        (in_w),
        .ack       (b_ack),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .err_clr   (1'b0),
        .err       (b_err),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    // Monitor: pops expectations whenever a DUT shows an ack pulse or completes a transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack != 2'b00) begin
                if (exp_ack.size() == 0) unexpected("a_ack", 32'(ack));
                else check("a_ack", 32'(ack), 32'(exp_ack.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (exp_dat.size() == 0) unexpected("a_xfer", 32'({out_sel, out_data}));
                else check("a_xfer", 32'({out_sel, out_data}), 32'(exp_dat.pop_front()));
            end
            if (out_valid && prev_valid_a && !prev_ready_a)
                check("a_stable", 32'({out_sel, out_data}), 32'(prev_word_a));
            if (b_ack != 2'b00) begin
                if (exp_b_ack.size() == 0) unexpected("b_ack", 32'(b_ack));
                else check("b_ack", 32'(b_ack), 32'(exp_b_ack.pop_front()));
            end
            if (b_out_valid && b_out_ready) begin
                if (exp_b.size() == 0) unexpected("b_xfer", 32'({b_out_sel, b_out_data}));
                else check("b_xfer", 32'({b_out_sel, b_out_data}), 32'(exp_b.pop_front()));
            end
            if (b_out_valid && prev_valid_b && !prev_ready_b)
                check("b_stable", 32'({b_out_sel, b_out_data}), 32'(prev_word_b));
            if (b_out_valid) b_valid_cycles++;
        end
        prev_valid_a = out_valid && !reset;
        prev_ready_a = out_ready;
        prev_word_a  = {out_sel, out_data};
        prev_valid_b = b_out_valid && !reset;
        prev_ready_b = b_out_ready;
        prev_word_b  = {b_out_sel, b_out_data};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid;
        reset       = 1'b0;
        req         = 2'b00;
        in_w        = '0;
        out_ready   = 1'b1;
        err_clr     = 1'b0;
        b_req       = 2'b00;
        b_out_ready = 1'b1;

        // Asynchronous reset: outputs must clear before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ack",       32'(ack),       32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sel",   32'(out_sel),   32'd0);
        check("rst_b_busy",    32'(b_busy),    32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Round robin with both requesters re-asserting after each ack: 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            in_w[0] = rr_w0[k];
            in_w[1] = rr_w1[k];
            req     = 2'b11;
            exp_ack.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
            exp_dat.push_back((k % 2 == 0) ? {1'b0, rr_w0[k]} : {1'b1, rr_w1[k]});
            tick();
            req = (k % 2 == 0) ? 2'b10 : 2'b01;
            tick();
        end
        req = 2'b00;
        tick();
        @(negedge clk);
        check("rr_idle_valid", 32'(out_valid), 32'd0);
        check("rr_idle_busy",  32'(busy),      32'd0);

        // Single grant of requester 0.
        tick();
        in_w[0] = 7'h2A;
        req     = 2'b01;
        exp_ack.push_back(2'b01);
        exp_dat.push_back({1'b0, 7'h2A});
        tick();
        req = 2'b00;
        tick();
        @(negedge clk);
        check("single_idle_valid", 32'(out_valid), 32'd0);
        check("single_idle_busy",  32'(busy),      32'd0);

        // Lone request from the last-served requester is still granted.
        tick();
        in_w[0] = 7'h45;
        req     = 2'b01;
        exp_ack.push_back(2'b01);
        exp_dat.push_back({1'b0, 7'h45});
        tick();
        req = 2'b00;
        tick();

        // Timeout with TIMEOUT=4: valid for 4 cycles, word dropped, err set.
        out_ready = 1'b0;
        in_w[1]   = 7'h5C;
        req       = 2'b10;
        exp_ack.push_back(2'b10);
        tick();
        req     = 2'b00;
        n_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) n_valid++;
        end
        @(negedge clk);
        check("to1_valid_cycles", 32'(n_valid),   32'd4);
        check("to1_out_valid",    32'(out_valid), 32'd0);
        check("to1_err",          32'(err),       32'd1);
        tick();
        tick();
        @(negedge clk);
        check("to1_err_sticky", 32'(err), 32'd1);

        // Second timeout with err_clr asserted in the drop cycle.
        tick();
        in_w[0] = 7'h66;
        req     = 2'b01;
        exp_ack.push_back(2'b01);
        tick();
        req = 2'b00;
        tick();
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("to2_err_clr_race", 32'(err),       32'd1);
        check("to2_out_valid",    32'(out_valid), 32'd0);

        // err_clr on its own clears err.
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", 32'(err), 32'd0);

        // out_ready rises exactly in the timer==TIMEOUT-1 cycle: transfer, no error.
        tick();
        out_ready = 1'b0;
        in_w[1]   = 7'h71;
        req       = 2'b10;
        exp_ack.push_back(2'b10);
        exp_dat.push_back({1'b1, 7'h71});
        tick();
        req = 2'b00;
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bound_err",       32'(err),       32'd0);
        check("bound_out_valid", 32'(out_valid), 32'd0);

        // Backpressure on the TIMEOUT=16 instance: 5 stalled cycles then accept.
        tick();
        in_w[0]     = 7'h3C;
        b_out_ready = 1'b0;
        b_req       = 2'b01;
        exp_b_ack.push_back(2'b01);
        exp_b.push_back({1'b0, 7'h3C});
        tick();
        b_req = 2'b00;
        repeat (5) tick();
        b_out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_out_valid", 32'(b_out_valid), 32'd0);
        check("bp_err",       32'(b_err),       32'd0);

        // Reset in the second SEND cycle drops the word without a clock edge.
        tick();
        out_ready = 1'b0;
        in_w[0]   = 7'h0F;
        req       = 2'b01;
        exp_ack.push_back(2'b01);
        tick();
        req = 2'b00;
        tick();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_ack",       32'(ack),       32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_w[0]   = 7'h21;
        in_w[1]   = 7'h42;
        req       = 2'b11;
        exp_ack.push_back(2'b01);
        exp_dat.push_back({1'b0, 7'h21});
        exp_ack.push_back(2'b10);
        exp_dat.push_back({1'b1, 7'h42});
        tick();
        req = 2'b10;
        tick();
        tick();
        req = 2'b00;
        tick();
        repeat (3) tick();

        @(negedge clk);
        check("a_ack_drained",  32'(exp_ack.size()),   32'd0);
        check("a_dat_drained",  32'(exp_dat.size()),   32'd0);
        check("b_ack_drained",  32'(exp_b_ack.size()), 32'd0);
        check("b_dat_drained",  32'(exp_b.size()),     32'd0);
        check("bp_valid_cycles", 32'(b_valid_cycles),  32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
